// File: rtl/ff_sr_pkg.sv
// ff_sr_pkg
//   Shared definitions for the clocked set/reset flip-flop (ff_sr).
//   - POL_* : encodings for the action taken when s and r are both 1.
//   - sr_req_e : the four possible {s, r} request combinations.
//   - sr_next() : next-state function for a single SR bit.
package ff_sr_pkg;

  // Policy applied to a bit when set and reset are requested together.
  localparam logic [1:0] POL_HOLD   = 2'd0;
  localparam logic [1:0] POL_SET    = 2'd1;
  localparam logic [1:0] POL_RST    = 2'd2;
  localparam logic [1:0] POL_TOGGLE = 2'd3;

  // The {s, r} pair viewed as a single request code.
  typedef enum logic [1:0] {
    REQ_HOLD = 2'b00,
    REQ_CLR  = 2'b01,
    REQ_SET  = 2'b10,
    REQ_BOTH = 2'b11
  } sr_req_e;

  // Next value of one SR bit given its current value, the requests and
  // the S=R=1 policy.
  function automatic logic sr_next(input logic       q,
                                   input logic       s,
                                   input logic       r,
                                   input logic [1:0] pol);
    logic nxt;
    nxt = q;
    case (sr_req_e'({s, r}))
      REQ_HOLD: nxt = q;
      REQ_CLR:  nxt = 1'b0;
      REQ_SET:  nxt = 1'b1;
      REQ_BOTH: begin
        case (pol)
          POL_HOLD:   nxt = q;
          POL_SET:    nxt = 1'b1;
          POL_RST:    nxt = 1'b0;
          POL_TOGGLE: nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_sr_cell.sv
// ff_sr_cell
//   One registered SR storage bit. The top level instantiates one of these
//   for every bit of its WIDTH-wide ports.
// Parameters:
//   RST_VAL : value loaded into q on a reset edge
//   POL     : action when s=r=1 (see ff_sr_pkg POL_*)
// Ports:
//   clk : clock, rising-edge active
//   rst : synchronous active-high reset
//   s   : set request
//   r   : reset request
//   q   : stored bit
module ff_sr_cell
  import ff_sr_pkg::*;
#(
  parameter logic       RST_VAL = 1'b0,
  parameter logic [1:0] POL     = POL_RST
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  // State register: reset has priority over any set/reset request on the
  // same edge; otherwise the package function chooses the next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= sr_next(q, s, r, POL);
    end
  end

endmodule

// File: rtl/ff_sr.sv
// ff_sr
//   Bank of WIDTH independent clocked set/reset flip-flops with a
//   complementary output and a selectable S=R=1 policy.
// Parameters:
//   WIDTH    : number of independent SR bits
//   RST_VAL  : value loaded into q on reset (qn gets ~RST_VAL)
//   BOTH_POL : action when s=r=1: 0 hold, 1 set wins, 2 reset wins, 3 toggle
// Ports:
//   clk : clock, rising-edge active
//   rst : synchronous active-high reset
//   s   : set requests, WIDTH bits
//   r   : reset requests, WIDTH bits
//   q   : stored state, WIDTH bits
//   qn  : ~q, WIDTH bits
//   err : sticky S=R=1 flag, present only when FFSR_ERR_EN is defined
// Optional feature macro: FFSR_ERR_EN
module ff_sr
  import ff_sr_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               BOTH_POL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
`ifdef FFSR_ERR_EN
  output logic [WIDTH-1:0] qn,
  output logic             err
`else
  output logic [WIDTH-1:0] qn
`endif
);

  // Only four policies exist; anything else is a build error.
  generate
    if ((BOTH_POL < 0) || (BOTH_POL > 3)) begin : g_bad_pol
      $fatal(1, "ff_sr: unsupported BOTH_POL value %0d", BOTH_POL);
    end
  endgenerate

  localparam logic [1:0] POL = BOTH_POL[1:0];

  // One storage cell per bit; bits never interact.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_sr_cell #(
        .RST_VAL(RST_VAL[i]),
        .POL    (POL)
      ) u_cell (
        .clk(clk),
        .rst(rst),
        .s  (s[i]),
        .r  (r[i]),
        .q  (q[i])
      );
    end
  endgenerate

  // qn carries no state of its own so it can never disagree with q.
  assign qn = ~q;

`ifdef FFSR_ERR_EN
  logic anyBoth;
  assign anyBoth = |(s & r);

  // Sticky flag: any bit seeing s=r=1 on a non-reset edge latches it
  // until the next reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (anyBoth) begin
      err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only warning on every offending edge.
  always @(posedge clk) begin
    if (!rst && anyBoth) begin
      $display("[%0t] Erro: Estado invalido! S=1 e R=1", $time);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_ff_sr.sv
// tb_ff_sr
//   Directed self-checking bench for ff_sr. Four 1-bit instances cover the
//   four S=R=1 policies and share one s/r pair; a fifth, 4-bit instance
//   with RST_VAL=4'b1010 covers bit slicing and non-zero reset values.
module tb_ff_sr;

  logic clk;
  logic rst;
  logic s;
  logic r;
  logic [3:0] s4;
  logic [3:0] r4;

  logic qP0, qP1, qP2, qP3;
  logic qnP0, qnP1, qnP2, qnP3;
  logic [3:0] qW;
  logic [3:0] qnW;
`ifdef FFSR_ERR_EN
  logic errP0, errP1, errP2, errP3, errW;
`endif

  logic [3:0] qPol;
  logic [3:0] qnPol;
  assign qPol  = {qP3, qP2, qP1, qP0};
  assign qnPol = {qnP3, qnP2, qnP1, qnP0};

  int testsRun;
  int testsFailed;
  logic resetSeen;

  ff_sr #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_POL(0)) u_pol0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(qP0),
`ifdef FFSR_ERR_EN
    .err(errP0),
`endif
    .qn(qnP0)
  );

  ff_sr #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_POL(1)) u_pol1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(qP1),
`ifdef FFSR_ERR_EN
    .err(errP1),
`endif
    .qn(qnP1)
  );

  ff_sr #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_POL(2)) u_pol2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(qP2),
`ifdef FFSR_ERR_EN
    .err(errP2),
`endif
    .qn(qnP2)
  );

  ff_sr #(.WIDTH(1), .RST_VAL(1'b0), .BOTH_POL(3)) u_pol3 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(qP3),
`ifdef FFSR_ERR_EN
    .err(errP3),
`endif
    .qn(qnP3)
  );

  ff_sr #(.WIDTH(4), .RST_VAL(4'b1010), .BOTH_POL(2)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(qW),
`ifdef FFSR_ERR_EN
    .err(errW),
`endif
    .qn(qnW)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // After the first reset edge no output may ever be X/Z (inputs are
  // always driven to known values by this bench).
  always @(negedge clk) begin
    if (resetSeen) begin
      testsRun++;
      if ($isunknown({qPol, qnPol, qW, qnW})) begin
        testsFailed++;
        $display("[TB] FAIL xcheck: outputs=%b required no X/Z", {qPol, qnPol, qW, qnW});
      end
    end
  end

  // Drive one set of inputs half a period before an edge, then return
  // just after that edge so outputs can be sampled.
  task automatic applyStimulus(input logic rstV, input logic sV, input logic rV,
                               input logic [3:0] s4V, input logic [3:0] r4V);
    @(negedge clk);
    rst = rstV;
    s   = sV;
    r   = rV;
    s4  = s4V;
    r4  = r4V;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0000 || qnPol !== 4'b1111) begin
      testsFailed++;
      $display("[TB] FAIL reset_beats_set: q=%b qn=%b required q=0000 qn=1111", qPol, qnPol);
    end
    testsRun++;
    if (qW !== 4'b1010 || qnW !== 4'b0101) begin
      testsFailed++;
      $display("[TB] FAIL reset_wide: q=%b qn=%b required q=1010 qn=0101", qW, qnW);
    end
    resetSeen = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b1111 || qnPol !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL set_after_reset: q=%b qn=%b required q=1111 qn=0000", qPol, qnPol);
    end
  endtask

  task automatic test_set_hold();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b1111 || qnPol !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL set: q=%b qn=%b required q=1111 qn=0000", qPol, qnPol);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
      testsRun++;
      if (qPol !== 4'b1111 || qnPol !== 4'b0000) begin
        testsFailed++;
        $display("[TB] FAIL hold_%0d: q=%b qn=%b required q=1111 qn=0000", i, qPol, qnPol);
      end
    end
  endtask

  task automatic test_clear();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0000 || qnPol !== 4'b1111) begin
      testsFailed++;
      $display("[TB] FAIL clear: q=%b qn=%b required q=0000 qn=1111", qPol, qnPol);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0000 || qnPol !== 4'b1111) begin
      testsFailed++;
      $display("[TB] FAIL clear_hold: q=%b qn=%b required q=0000 qn=1111", qPol, qnPol);
    end
  endtask

  // Bit order in qPol is {pol3, pol2, pol1, pol0}.
  task automatic test_both();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0011 || qnPol !== 4'b1100) begin
      testsFailed++;
      $display("[TB] FAIL both_once: q=%b qn=%b required q=0011 qn=1100", qPol, qnPol);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b1011 || qnPol !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL both_twice: q=%b qn=%b required q=1011 qn=0100", qPol, qnPol);
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0000 || qW !== 4'b1010) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: q=%b qw=%b required q=0000 qw=1010", qPol, qW);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b0000 || qW !== 4'b1010) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_hold: q=%b qw=%b required q=0000 qw=1010", qPol, qW);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qPol !== 4'b1111) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_set: q=%b required q=1111", qPol);
    end
  endtask

  task automatic test_width();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (qW !== 4'b1010 || qnW !== 4'b0101) begin
      testsFailed++;
      $display("[TB] FAIL width_reset: q=%b qn=%b required q=1010 qn=0101", qW, qnW);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101, 4'b1000);
    testsRun++;
    if (qW !== 4'b0111 || qnW !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL width_mixed: q=%b qn=%b required q=0111 qn=1000", qW, qnW);
    end
    // Bits 3,2 plain set; bits 1,0 see s=r=1 and reset wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011);
    testsRun++;
    if (qW !== 4'b1100 || qnW !== 4'b0011) begin
      testsFailed++;
      $display("[TB] FAIL width_both: q=%b qn=%b required q=1100 qn=0011", qW, qnW);
    end
  endtask

`ifdef FFSR_ERR_EN
  task automatic test_err();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    testsRun++;
    if (errP2 !== 1'b0 || errW !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_reset: err=%b errw=%b required 0 0", errP2, errW);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    testsRun++;
    if (errP2 !== 1'b1 || errW !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_set: err=%b errw=%b required 1 0", errP2, errW);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100);
    testsRun++;
    if (errP2 !== 1'b1 || errW !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err_sticky: err=%b errw=%b required 1 1", errP2, errW);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);
    testsRun++;
    if (errP2 !== 1'b0 || errW !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_clear: err=%b errw=%b required 0 0", errP2, errW);
    end
  endtask
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetSeen   = 1'b0;
    rst = 1'b1;
    s   = 1'b0;
    r   = 1'b0;
    s4  = 4'b0000;
    r4  = 4'b0000;

    test_reset();
    test_set_hold();
    test_clear();
    test_both();
    test_mid_reset();
    test_width();
`ifdef FFSR_ERR_EN
    test_err();
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
